regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between two requesters: the pipeline writeback stage (P) and the multdiv completion path (M).
- Keeps a busy scoreboard of registers with an outstanding multdiv result and raises a stall for dependent reads.
- Registered outputs drive the regfile write inputs directly.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file writeback arbiter.
// Both requesters share one regfile write port through this arbiter.
package regfile_wb_arbiter_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_P    = 2'd1,
      GNT_M    = 2'd2
   } gnt_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for registers awaiting a multdiv result.
// Provides the decode stall, the P-side WAW lookup and the sticky double-issue error.
module wb_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int REG_ADDR_W = regfile_wb_arbiter_pkg::REG_ADDR_W
)(
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_reg,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_reg,
   input  logic [REG_ADDR_W-1:0] chk_a,
   input  logic [REG_ADDR_W-1:0] chk_b,
   input  logic [REG_ADDR_W-1:0] look_reg,
   output logic                  look_busy,
   output logic                  stall,
   output logic                  sb_err
);

   localparam int SB_REGS = 2 ** REG_ADDR_W;

   logic [SB_REGS-1:0] busy;
   logic [SB_REGS-1:0] busy_nxt;
   logic               set_live;
   logic               dbl_issue;

   assign set_live  = set_en && (set_reg != '0);
   assign dbl_issue = set_live && busy[set_reg];

   // Clear first, then set, so a same-cycle issue to the completing register keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (clr_en) begin
         busy_nxt[clr_reg] = 1'b0;
      end
      if (set_live) begin
         busy_nxt[set_reg] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (dbl_issue) begin
            sb_err <= 1'b1;
         end
      end
   end

   // Lookups use registered state only; a completion this cycle releases stall next cycle.
   assign look_busy = busy[look_reg];
   assign stall     = ((chk_a != '0) && busy[chk_a]) ||
                      ((chk_b != '0) && busy[chk_b]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback (P) and multdiv (M).
// M has priority; P is forced ahead after STARVE_LIMIT consecutive blocked cycles.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = regfile_wb_arbiter_pkg::DATA_WIDTH,
   parameter int REG_ADDR_W   = regfile_wb_arbiter_pkg::REG_ADDR_W,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  p_valid,
   input  logic [REG_ADDR_W-1:0] p_reg,
   input  logic [DATA_WIDTH-1:0] p_data,
   output logic                  p_ready,
   input  logic                  m_valid,
   input  logic [REG_ADDR_W-1:0] m_reg,
   input  logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_ready,
   input  logic                  md_issue,
   input  logic [REG_ADDR_W-1:0] md_issue_reg,
   input  logic [REG_ADDR_W-1:0] chk_regA,
   input  logic [REG_ADDR_W-1:0] chk_regB,
   output logic                  stall,
   output logic                  sb_err,
   output logic                  ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0] ctrl_writeReg,
   output logic [DATA_WIDTH-1:0] data_writeReg
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   gnt_e              gnt;
   logic              p_busy;
   logic              p_elig;
   logic              m_elig;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic [REG_ADDR_W-1:0] sel_reg;
   logic [DATA_WIDTH-1:0] sel_data;

   wb_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_sb (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .set_en       (md_issue),
      .set_reg      (md_issue_reg),
      .clr_en       (m_ready),
      .clr_reg      (m_reg),
      .chk_a        (chk_regA),
      .chk_b        (chk_regB),
      .look_reg     (p_reg),
      .look_busy    (p_busy),
      .stall        (stall),
      .sb_err       (sb_err)
   );

   // P may not overwrite a register still waiting on its multdiv result.
   assign p_elig = p_valid && !p_busy;
   assign m_elig = m_valid;

   always_comb begin
      gnt = GNT_NONE;
      if (p_elig && m_elig) begin
         gnt = (starve_cnt == CNT_MAX) ? GNT_P : GNT_M;
      end else if (m_elig) begin
         gnt = GNT_M;
      end else if (p_elig) begin
         gnt = GNT_P;
      end
   end

   assign p_ready = (gnt == GNT_P);
   assign m_ready = (gnt == GNT_M);

   always_comb begin
      starve_nxt = '0;
      if (p_elig && (gnt != GNT_P)) begin
         starve_nxt = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      sel_reg  = ctrl_writeReg;
      sel_data = data_writeReg;
      if (gnt == GNT_P) begin
         sel_reg  = p_reg;
         sel_data = p_data;
      end else if (gnt == GNT_M) begin
         sel_reg  = m_reg;
         sel_data = m_data;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_nxt;
      end
   end

   // Output stage: registered regfile write, one cycle after the transfer edge.
   // Writes to register 0 are accepted upstream but never enabled.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
      end else begin
         ctrl_writeEnable <= (gnt != GNT_NONE) && (sel_reg != '0);
         ctrl_writeReg    <= sel_reg;
         data_writeReg    <= sel_data;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, starvation override, scoreboard and reset.
// Expected values are hand-derived from the handshake and write-latency rules.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic        p_valid, m_valid, md_issue;
   logic [4:0]  p_reg, m_reg, md_issue_reg, chk_regA, chk_regB;
   logic [31:0] p_data, m_data;
   logic        p_ready, m_ready, stall, sb_err, ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   regfile_wb_arbiter #(
      .DATA_WIDTH   (32),
      .REG_ADDR_W   (5),
      .STARVE_LIMIT (4)
   ) dut (
      .clock            (clock),
      .ctrl_reset_n     (ctrl_reset_n),
      .p_valid          (p_valid),
      .p_reg            (p_reg),
      .p_data           (p_data),
      .p_ready          (p_ready),
      .m_valid          (m_valid),
      .m_reg            (m_reg),
      .m_data           (m_data),
      .m_ready          (m_ready),
      .md_issue         (md_issue),
      .md_issue_reg     (md_issue_reg),
      .chk_regA         (chk_regA),
      .chk_regB         (chk_regB),
      .stall            (stall),
      .sb_err           (sb_err),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      ctrl_reset_n = 1'b0;
      p_valid = 0; p_reg = 0; p_data = 0;
      m_valid = 0; m_reg = 0; m_data = 0;
      md_issue = 0; md_issue_reg = 0;
      chk_regA = 0; chk_regB = 0;
      #12;
      chk("rst_wen", ctrl_writeEnable, 0);
      chk("rst_wreg", ctrl_writeReg, 0);
      chk("rst_wdata", data_writeReg, 0);
      chk("rst_stall", stall, 0);
      chk("rst_sberr", sb_err, 0);
      ctrl_reset_n = 1'b1;
      step();

      // 1: P alone
      p_valid = 1; p_reg = 5; p_data = 32'h1234;
      #1;
      chk("t1_pready", p_ready, 1);
      chk("t1_mready", m_ready, 0);
      step();
      p_valid = 0;
      chk("t1_wen", ctrl_writeEnable, 1);
      chk("t1_wreg", ctrl_writeReg, 5);
      chk("t1_wdata", data_writeReg, 32'h1234);
      step();
      chk("t1_wen_off", ctrl_writeEnable, 0);
      chk("t1_wreg_hold", ctrl_writeReg, 5);
      chk("t1_wdata_hold", data_writeReg, 32'h1234);

      // 2: contention, P forced through after 4 blocked cycles, twice
      p_valid = 1; p_reg = 3; p_data = 32'hAAAA_0003;
      m_valid = 1; m_reg = 7; m_data = 32'hBBBB_0007;
      for (int i = 0; i < 11; i++) begin
         automatic logic pw = (i == 4) || (i == 9);
         #1;
         chk("t2_pready", p_ready, pw);
         chk("t2_mready", m_ready, !pw);
         step();
         chk("t2_wen", ctrl_writeEnable, 1);
         chk("t2_wreg", ctrl_writeReg, pw ? 32'd3 : 32'd7);
         chk("t2_wdata", data_writeReg, pw ? 32'hAAAA_0003 : 32'hBBBB_0007);
      end
      p_valid = 0; m_valid = 0;
      step();
      chk("t2_idle_wen", ctrl_writeEnable, 0);

      // 3: scoreboard stall and WAW guard
      md_issue = 1; md_issue_reg = 9;
      step();
      md_issue = 0; chk_regA = 9;
      p_valid = 1; p_reg = 9; p_data = 32'hC0C0_0009;
      #1;
      chk("t3_stall", stall, 1);
      chk("t3_pblock", p_ready, 0);
      step();
      chk("t3_stall_hold", stall, 1);
      chk("t3_nowrite", ctrl_writeEnable, 0);
      m_valid = 1; m_reg = 9; m_data = 32'hD0D0_0009;
      #1;
      chk("t3_mready", m_ready, 1);
      chk("t3_pready_blk", p_ready, 0);
      chk("t3_stall_same", stall, 1);
      step();
      m_valid = 0;
      #1;
      chk("t3_stall_rel", stall, 0);
      chk("t3_pready_ok", p_ready, 1);
      chk("t3_m_wen", ctrl_writeEnable, 1);
      chk("t3_m_wdata", data_writeReg, 32'hD0D0_0009);
      step();
      p_valid = 0; chk_regA = 0;
      chk("t3_p_wreg", ctrl_writeReg, 9);
      chk("t3_p_wdata", data_writeReg, 32'hC0C0_0009);

      // 4: same-cycle set and clear, then double issue
      md_issue = 1; md_issue_reg = 12;
      m_valid = 1; m_reg = 12; m_data = 32'hE0E0_000C;
      chk_regB = 12;
      #1;
      chk("t4_mready", m_ready, 1);
      chk("t4_stall_pre", stall, 0);
      step();
      md_issue = 0; m_valid = 0;
      chk("t4_busy_set", stall, 1);
      chk("t4_sberr0", sb_err, 0);
      md_issue = 1; md_issue_reg = 12;
      step();
      md_issue = 0;
      chk("t4_sberr1", sb_err, 1);
      step();
      chk("t4_sberr_hold", sb_err, 1);
      chk("t4_busy_kept", stall, 1);
      chk_regB = 0;

      // 5: write to r0 accepted but not enabled
      p_valid = 1; p_reg = 0; p_data = 32'hFFFF_FFFF; chk_regA = 0;
      #1;
      chk("t5_pready", p_ready, 1);
      chk("t5_stall", stall, 0);
      step();
      p_valid = 0;
      chk("t5_wen", ctrl_writeEnable, 0);
      chk("t5_wdata", data_writeReg, 32'hFFFF_FFFF);

      // 6: asynchronous reset mid-cycle
      md_issue = 1; md_issue_reg = 4;
      step();
      md_issue = 0;
      p_valid = 1; p_reg = 6; p_data = 32'h77;
      step();
      p_valid = 0; chk_regA = 4;
      #1;
      chk("t6_pre_wen", ctrl_writeEnable, 1);
      chk("t6_pre_stall", stall, 1);
      chk("t6_pre_sberr", sb_err, 1);
      ctrl_reset_n = 1'b0;
      #1;
      chk("t6_wen", ctrl_writeEnable, 0);
      chk("t6_stall", stall, 0);
      chk("t6_sberr", sb_err, 0);
      chk("t6_wreg", ctrl_writeReg, 0);
      chk("t6_wdata", data_writeReg, 0);
      ctrl_reset_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
